// File: rtl/fnn_wsel_ctrl_pkg.sv
// Shared types and constants for the FNN weight-select layer sequencer.
package fnn_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        MAC   = 3'd2,
        DRAIN = 3'd3,
        OUT   = 3'd4,
        FIN   = 3'd5
    } state_t;

    localparam int SEL_W  = 2;
    localparam int LANE_W = 6;
    localparam int WGT_W  = 8;

    localparam logic [LANE_W-1:0] LANES_FULL = 6'd62;
    localparam logic [LANE_W-1:0] LANES_LAST = 6'd30;

    // Bank 3 is the narrow, zero-extended bank.
    function automatic logic [LANE_W-1:0] grp_lanes(input logic [SEL_W-1:0] g);
        return (g == SEL_W'(3)) ? LANES_LAST : LANES_FULL;
    endfunction

endpackage

// File: rtl/fnn_wsel_ctrl_if.sv
// Control/result bus between the layer FSM, the sequencer and the MAC datapath.
// FNN_WSEL_PERF_EN adds the stall_cnt / layer_cyc performance counters.
interface fnn_wsel_ctrl_if #(parameter int ADDR_W = 6);
    import fnn_ctrl_pkg::*;

    logic              start;
    logic              busy;
    logic              done;
    logic [SEL_W-1:0]  sel;
    logic [ADDR_W-1:0] in_addr;
    logic              mac_en;
    logic              acc_clr;
    logic              out_valid;
    logic              out_ready;
    logic [SEL_W-1:0]  out_group;
    logic [LANE_W-1:0] out_lanes;
`ifdef FNN_WSEL_PERF_EN
    logic [15:0]       stall_cnt;
    logic [15:0]       layer_cyc;

    modport master (input start, out_ready,
                    output busy, done, sel, in_addr, mac_en, acc_clr,
                           out_valid, out_group, out_lanes, stall_cnt, layer_cyc);
    modport slave  (output start, out_ready,
                    input busy, done, sel, in_addr, mac_en, acc_clr,
                          out_valid, out_group, out_lanes, stall_cnt, layer_cyc);
`else
    modport master (input start, out_ready,
                    output busy, done, sel, in_addr, mac_en, acc_clr,
                           out_valid, out_group, out_lanes);
    modport slave  (output start, out_ready,
                    input busy, done, sel, in_addr, mac_en, acc_clr,
                          out_valid, out_group, out_lanes);
`endif

endinterface

// File: rtl/fnn_step_cnt.sv
// Up-counter cleared by load, stepping while enabled and parking at its terminal count.
module fnn_step_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] q,
    output logic         tc
);

    assign tc = (q == tc_val);

    always_ff @(posedge clk) begin
        if (rst || load)
            q <= '0;
        else if (en && !tc)
            q <= q + 1'b1;
    end

endmodule

// File: rtl/fnn_wsel_ctrl.sv
// FNN layer sequencer: steps the weight-bank select, streams MAC addresses, drains, hands off.
// Optional FNN_WSEL_PERF_EN: stall_cnt / layer_cyc performance counters on the bus.
module fnn_wsel_ctrl
    import fnn_ctrl_pkg::*;
#(
    parameter int IN_LEN   = 62,
    parameter int ADDR_W   = 6,
    parameter int PIPE_LAT = 3,
    parameter int NUM_GRP  = 4
) (
    input  logic            clk,
    input  logic            rst,
    fnn_wsel_ctrl_if.master bus
);

    localparam logic [ADDR_W-1:0] ADDR_TC  = ADDR_W'(IN_LEN - 1);
    localparam logic [3:0]        DRAIN_TC = 4'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);
    localparam logic [SEL_W-1:0]  LAST_GRP = SEL_W'(NUM_GRP - 1);

    state_t           state;
    logic [SEL_W-1:0] grp;
    logic             addr_tc, drain_tc, xfer, enter_clr;
    logic [3:0]       drain_q;

    assign xfer      = (state == OUT) && bus.out_ready;
    assign enter_clr = ((state == IDLE) && bus.start) || (xfer && grp != LAST_GRP);

    // Address counter is zeroed on CLR entry so CLR itself presents address 0.
    fnn_step_cnt #(.W(ADDR_W)) u_addr (
        .clk    (clk),
        .rst    (rst),
        .load   (enter_clr),
        .en     (state == MAC),
        .tc_val (ADDR_TC),
        .q      (bus.in_addr),
        .tc     (addr_tc)
    );

    fnn_step_cnt #(.W(4)) u_drain (
        .clk    (clk),
        .rst    (rst),
        .load   ((state == MAC) && addr_tc),
        .en     (state == DRAIN),
        .tc_val (DRAIN_TC),
        .q      (drain_q),
        .tc     (drain_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            grp           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sel       <= '0;
            bus.mac_en    <= 1'b0;
            bus.acc_clr   <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_group <= '0;
            bus.out_lanes <= '0;
        end else begin
            bus.done    <= 1'b0;
            bus.acc_clr <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state       <= CLR;
                    grp         <= '0;
                    bus.sel     <= '0;
                    bus.acc_clr <= 1'b1;
                    bus.busy    <= 1'b1;
                end
                CLR: begin
                    state      <= MAC;
                    bus.mac_en <= 1'b1;
                end
                MAC: if (addr_tc) begin
                    bus.mac_en <= 1'b0;
                    if (PIPE_LAT == 0) begin
                        state         <= OUT;
                        bus.out_valid <= 1'b1;
                        bus.out_group <= grp;
                        bus.out_lanes <= grp_lanes(grp);
                    end else begin
                        state <= DRAIN;
                    end
                end
                DRAIN: if (drain_tc) begin
                    state         <= OUT;
                    bus.out_valid <= 1'b1;
                    bus.out_group <= grp;
                    bus.out_lanes <= grp_lanes(grp);
                end
                OUT: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    if (grp == LAST_GRP) begin
                        state    <= FIN;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end else begin
                        state       <= CLR;
                        grp         <= grp + 1'b1;
                        bus.sel     <= grp + 1'b1;
                        bus.acc_clr <= 1'b1;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FNN_WSEL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst || ((state == IDLE) && bus.start)) begin
            bus.stall_cnt <= '0;
            bus.layer_cyc <= '0;
        end else begin
            if ((state == OUT) && !bus.out_ready && bus.stall_cnt != 16'hFFFF)
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
            if (bus.busy && bus.layer_cyc != 16'hFFFF)
                bus.layer_cyc <= bus.layer_cyc + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fnn_wsel_ctrl.sv
// Bench for fnn_wsel_ctrl: a default instance (62/3) and a minimal one (IN_LEN=1, PIPE_LAT=0).
module tb_fnn_wsel_ctrl;
    import fnn_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fnn_wsel_ctrl_if #(.ADDR_W(6)) ia ();
    fnn_wsel_ctrl_if #(.ADDR_W(6)) ib ();

    fnn_wsel_ctrl #(.IN_LEN(62), .ADDR_W(6), .PIPE_LAT(3), .NUM_GRP(4))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    fnn_wsel_ctrl #(.IN_LEN(1), .ADDR_W(6), .PIPE_LAT(0), .NUM_GRP(4))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [1:0] sel;
        logic [5:0] addr;
        logic       mac_en;
        logic       acc_clr;
        logic       ov;
        logic [1:0] grp;
        logic [5:0] lanes;
    } obs_t;

    typedef struct {
        obs_t e;
        bit   addr_chk;
        bit   sel_chk;
        bit   rdy;
    } step_t;

    typedef struct {
        int w;
        int s0, s1, s2, s3;
        bit poke;
        int gap;
        int exp_done;
        int exp_stall;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0d got=%h want=%h", name, t, act, exp);
        end
    endtask

    function automatic obs_t sample(input int w);
        obs_t o;
        if (w == 0) o = '{ia.busy, ia.done, ia.sel, ia.in_addr, ia.mac_en, ia.acc_clr,
                          ia.out_valid, ia.out_group, ia.out_lanes};
        else        o = '{ib.busy, ib.done, ib.sel, ib.in_addr, ib.mac_en, ib.acc_clr,
                          ib.out_valid, ib.out_group, ib.out_lanes};
        return o;
    endfunction

    task automatic drive(input int w, input bit st, input bit rd);
        ia.start     = (w == 0) && st;
        ib.start     = (w == 1) && st;
        ia.out_ready = (w == 0) ? rd : 1'b0;
        ib.out_ready = (w == 1) ? rd : 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle trace of one layer, built straight from the group recipe.
    task automatic run_layer(input int w, input int st0, input int st1, input int st2, input int st3,
                             input bit poke, input int exp_done, input int exp_stall);
        step_t q[$];
        step_t s;
        obs_t  a;
        int    stl[4];
        int    len, plat, first_done, ndone;
        stl[0] = st0; stl[1] = st1; stl[2] = st2; stl[3] = st3;
        len  = (w == 0) ? 62 : 1;
        plat = (w == 0) ? 3 : 0;
        for (int g = 0; g < 4; g++) begin
            s = '{e: '0, addr_chk: 1'b1, sel_chk: 1'b1, rdy: 1'b0};
            s.e.busy = 1'b1; s.e.sel = 2'(g); s.e.acc_clr = 1'b1; s.rdy = 1'($urandom % 2);
            q.push_back(s);
            for (int k = 0; k < len; k++) begin
                s = '{e: '0, addr_chk: 1'b1, sel_chk: 1'b1, rdy: 1'($urandom % 2)};
                s.e.busy = 1'b1; s.e.sel = 2'(g); s.e.addr = 6'(k); s.e.mac_en = 1'b1;
                q.push_back(s);
            end
            for (int d = 0; d < plat; d++) begin
                s = '{e: '0, addr_chk: 1'b0, sel_chk: 1'b1, rdy: 1'($urandom % 2)};
                s.e.busy = 1'b1; s.e.sel = 2'(g);
                q.push_back(s);
            end
            for (int k = 0; k <= stl[g]; k++) begin
                s = '{e: '0, addr_chk: 1'b0, sel_chk: 1'b1, rdy: (k == stl[g])};
                s.e.busy = 1'b1; s.e.sel = 2'(g); s.e.ov = 1'b1; s.e.grp = 2'(g);
                s.e.lanes = (g == 3) ? 6'd30 : 6'd62;
                q.push_back(s);
            end
        end
        s = '{e: '0, addr_chk: 1'b0, sel_chk: 1'b0, rdy: 1'($urandom % 2)};
        s.e.done = 1'b1;
        q.push_back(s);

        drive(w, 1'b1, 1'($urandom % 2));
        tick();
        first_done = 0;
        ndone      = 0;
        for (int i = 0; i < q.size(); i++) begin
            s = q[i];
            a = sample(w);
            if (a.done) begin
                ndone++;
                if (first_done == 0) first_done = i + 1;
            end
            if (!s.addr_chk) a.addr = s.e.addr;
            if (!s.sel_chk)  a.sel  = s.e.sel;
            if (!s.e.ov) begin a.grp = s.e.grp; a.lanes = s.e.lanes; end
            check("trace", i + 1, 32'(a), 32'(s.e));
            drive(w, poke && (i + 1 == 5 || i + 1 == q.size()), s.rdy);
            tick();
        end
        a = sample(w);
        check("idle_after_fin", 0, {27'd0, a.busy, a.done, a.mac_en, a.acc_clr, a.ov}, 32'd0);
        check("done_cycle", 0, 32'(first_done), 32'(exp_done));
        check("done_count", 0, 32'(ndone), 32'd1);
`ifdef FNN_WSEL_PERF_EN
        check("stall_cnt", 0, 32'((w == 0) ? ia.stall_cnt : ib.stall_cnt), 32'(exp_stall));
        check("layer_cyc", 0, 32'((w == 0) ? ia.layer_cyc : ib.layer_cyc), 32'(exp_done - 1));
`else
        if (exp_stall < 0) $display("negative stall expectation %0d", exp_stall);
`endif
    endtask

    task automatic idle_gap(input int w, input int n);
        obs_t a;
        for (int i = 0; i < n; i++) begin
            drive(w, 1'b0, 1'($urandom % 2));
            tick();
            a = sample(w);
            check("idle_gap", i, {30'd0, a.busy, a.done}, 32'd0);
        end
    endtask

    vec_t tbl[6];
    obs_t a;
    bit   found;
    int   w, s0, s1, s2, s3, exp_d, len, plat;

    initial begin
        tbl[0] = '{w: 0, s0: 0, s1: 0,  s2: 0, s3: 0, poke: 0, gap: 0, exp_done: 269, exp_stall: 0};
        tbl[1] = '{w: 0, s0: 0, s1: 10, s2: 0, s3: 0, poke: 0, gap: 2, exp_done: 279, exp_stall: 10};
        tbl[2] = '{w: 0, s0: 0, s1: 0,  s2: 0, s3: 0, poke: 1, gap: 0, exp_done: 269, exp_stall: 0};
        tbl[3] = '{w: 0, s0: 0, s1: 0,  s2: 0, s3: 0, poke: 0, gap: 1, exp_done: 269, exp_stall: 0};
        tbl[4] = '{w: 1, s0: 0, s1: 0,  s2: 0, s3: 0, poke: 0, gap: 0, exp_done: 13,  exp_stall: 0};
        tbl[5] = '{w: 1, s0: 2, s1: 0,  s2: 1, s3: 3, poke: 0, gap: 3, exp_done: 19,  exp_stall: 6};

        drive(0, 1'b0, 1'b0);
        rst = 1'b1;
        tick(); tick();
        check("reset_a", 0, 32'(sample(0)), 32'd0);
        check("reset_b", 0, 32'(sample(1)), 32'd0);
`ifdef FNN_WSEL_PERF_EN
        check("reset_perf", 0, {ia.stall_cnt, ia.layer_cyc}, 32'd0);
`endif
        rst = 1'b0;
        tick();

        for (int r = 0; r < 6; r++) begin
            run_layer(tbl[r].w, tbl[r].s0, tbl[r].s1, tbl[r].s2, tbl[r].s3,
                      tbl[r].poke, tbl[r].exp_done, tbl[r].exp_stall);
            idle_gap(tbl[r].w, tbl[r].gap);
        end

        // Reset in group 2 mid-MAC, then a clean restart from sel 0.
        drive(0, 1'b1, 1'b1);
        tick();
        drive(0, 1'b0, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            a = sample(0);
            if (a.sel == 2'd2 && a.addr == 6'd20 && a.mac_en) found = 1'b1;
            else tick();
        end
        check("reach_g2_a20", 0, 32'(found), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_mac", 0, 32'(sample(0)), 32'd0);
        rst = 1'b0;
        idle_gap(0, 4);
        run_layer(0, 0, 0, 0, 0, 1'b0, 269, 0);

        for (int r = 0; r < 6; r++) begin
            w  = int'($urandom % 2);
            s0 = int'($urandom_range(0, 6)); s1 = int'($urandom_range(0, 6));
            s2 = int'($urandom_range(0, 6)); s3 = int'($urandom_range(0, 6));
            len   = (w == 0) ? 62 : 1;
            plat  = (w == 0) ? 3 : 0;
            exp_d = 4 * (2 + len + plat) + s0 + s1 + s2 + s3 + 1;
            run_layer(w, s0, s1, s2, s3, 1'b0, exp_d, s0 + s1 + s2 + s3);
            idle_gap(w, int'($urandom % 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
